// File: rtl/isp_frame_sequencer_pkg.sv
// Shared types and defaults for the ISP frame sequencer and its neighbours.
package isp_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ACTIVE,
    S_FBLANK,
    S_FROW,
    S_DONE
  } seq_state_t;

  // Bayer phase of the first pixel of a frame, shared with the demosaic stage.
  typedef enum logic [1:0] {
    BAYER_GB,
    BAYER_BG,
    BAYER_RG,
    BAYER_GR
  } bayer_phase_t;

  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_WIDTH       = 320;
  localparam int unsigned DEF_HEIGHT      = 240;
  localparam int unsigned DEF_H_BLANK     = 16;
  localparam int unsigned DEF_START_DELAY = 32;
  localparam int unsigned DEF_FLUSH_ROWS  = 8;

  // Index width for a range of n values, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/isp_frame_sequencer_if.sv
// Sensor-side inputs and pipeline-side outputs of the frame sequencer.
interface isp_frame_sequencer_if
  import isp_frame_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned HEIGHT     = DEF_HEIGHT,
  parameter int unsigned FLUSH_ROWS = DEF_FLUSH_ROWS
);
  localparam int unsigned RW = cnt_w(HEIGHT + FLUSH_ROWS);
  localparam int unsigned CW = cnt_w(WIDTH);

  logic              newFrame;
  logic              iValid;
  logic [DATA_W-1:0] iData;
  logic              iPipeDone;
  logic              oNewFrame;
  logic              oValid;
  logic [DATA_W-1:0] oData;
  logic [RW-1:0]     oRow;
  logic [CW-1:0]     oCol;
  logic              oBusy;
  logic              oFrameDone;
  logic              oOverrun;
  logic              oFrameErr;

  modport master (
    input  newFrame, iValid, iData, iPipeDone,
    output oNewFrame, oValid, oData, oRow, oCol, oBusy, oFrameDone, oOverrun, oFrameErr
  );

  modport slave (
    output newFrame, iValid, iData, iPipeDone,
    input  oNewFrame, oValid, oData, oRow, oCol, oBusy, oFrameDone, oOverrun, oFrameErr
  );

endinterface

// File: rtl/isp_frame_sequencer_span_counter.sv
// Loadable down-counter that parks at zero; used for the start and blanking delays.
module isp_frame_sequencer_span_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = load_val_i;
    else if (en_i && (count_q != '0))
      count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/isp_frame_sequencer.sv
// Frame sequencer: gates the sensor stream into the ISP pipeline and appends
// zero-data flush rows so the line-buffered kernels drain at end of frame.
module isp_frame_sequencer
  import isp_frame_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned HEIGHT      = DEF_HEIGHT,
  parameter int unsigned H_BLANK     = DEF_H_BLANK,
  parameter int unsigned START_DELAY = DEF_START_DELAY,
  parameter int unsigned FLUSH_ROWS  = DEF_FLUSH_ROWS
) (
  input  logic                  clk,
  input  logic                  reset,
  isp_frame_sequencer_if.master seq
);
  localparam int unsigned RW      = cnt_w(HEIGHT + FLUSH_ROWS);
  localparam int unsigned CW      = cnt_w(WIDTH);
  localparam int unsigned FW      = cnt_w(FLUSH_ROWS);
  localparam int unsigned DLY_MAX = (START_DELAY > H_BLANK) ? START_DELAY : H_BLANK;
  localparam int unsigned DW      = cnt_w(DLY_MAX);

  seq_state_t        state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [FW-1:0]     flush_q, flush_d;
  logic              seen_q, seen_d;
  logic              pend_q, pend_d;

  logic              nf_q, nf_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [RW-1:0]     orow_q, orow_d;
  logic [CW-1:0]     ocol_q, ocol_d;
  logic              busy_q, busy_d;
  logic              fdone_q, fdone_d;
  logic              ovr_q, ovr_d;
  logic              ferr_q, ferr_d;

  logic start_ld, start_zero, blank_ld, blank_zero;
  logic beat_ok, last_col, last_row, last_flush;

  // A beat in the same cycle as an aborting newFrame belongs to no frame and is dropped.
  assign beat_ok    = (state_q == S_ACTIVE) && seq.iValid && !seq.newFrame;
  assign last_col   = (col_q == CW'(WIDTH - 1));
  assign last_row   = (row_q == RW'(HEIGHT - 1));
  assign last_flush = (flush_q == FW'(FLUSH_ROWS - 1));
  assign start_ld   = (state_d == S_START)  && (state_q != S_START);
  assign blank_ld   = (state_d == S_FBLANK) && (state_q != S_FBLANK);

  isp_frame_sequencer_span_counter #(.CNT_W(DW)) u_start_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (start_ld),
    .load_val_i (DW'(START_DELAY - 1)),
    .en_i       (state_q == S_START),
    .zero_o     (start_zero)
  );

  isp_frame_sequencer_span_counter #(.CNT_W(DW)) u_blank_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (blank_ld),
    .load_val_i (DW'(H_BLANK - 1)),
    .en_i       (state_q == S_FBLANK),
    .zero_o     (blank_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (seq.newFrame) state_d = S_START;
      S_START:  if (start_zero) state_d = S_ACTIVE;
      S_ACTIVE: begin
        if (seq.newFrame)
          state_d = S_START;
        else if (seq.iValid && last_col && last_row)
          state_d = S_FBLANK;
      end
      S_FBLANK: if (blank_zero) state_d = S_FROW;
      S_FROW: begin
        if (last_col)
          state_d = (seen_q || seq.iPipeDone || last_flush) ? S_DONE : S_FBLANK;
      end
      S_DONE:   state_d = (pend_q || seq.newFrame) ? S_START : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    flush_d = flush_q;
    seen_d  = seen_q;
    pend_d  = pend_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    nf_d    = start_ld;
    vld_d   = beat_ok || (state_q == S_FROW);
    data_d  = beat_ok ? seq.iData : '0;
    busy_d  = (state_d != S_IDLE);
    fdone_d = (state_d == S_DONE);
    ovr_d   = seq.iValid && !beat_ok;
    ferr_d  = (state_q == S_ACTIVE) && seq.newFrame;
    case (state_q)
      S_START: begin
        col_d = '0;
        row_d = '0;
      end
      S_ACTIVE: begin
        if (beat_ok) begin
          orow_d = row_q;
          ocol_d = col_q;
          if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + RW'(1);
            if (last_row) begin
              flush_d = '0;
              seen_d  = 1'b0;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_FBLANK: begin
        seen_d = seen_q | seq.iPipeDone;
        pend_d = pend_q | seq.newFrame;
      end
      S_FROW: begin
        seen_d = seen_q | seq.iPipeDone;
        pend_d = pend_q | seq.newFrame;
        orow_d = RW'(HEIGHT) + RW'(flush_q);
        ocol_d = col_q;
        if (last_col) begin
          col_d = '0;
          if (state_d == S_FBLANK) flush_d = flush_q + FW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      S_DONE:  pend_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      flush_q <= '0;
      seen_q  <= 1'b0;
      pend_q  <= 1'b0;
      nf_q    <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      orow_q  <= '0;
      ocol_q  <= '0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      flush_q <= flush_d;
      seen_q  <= seen_d;
      pend_q  <= pend_d;
      nf_q    <= nf_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign seq.oNewFrame  = nf_q;
  assign seq.oValid     = vld_q;
  assign seq.oData      = data_q;
  assign seq.oRow       = orow_q;
  assign seq.oCol       = ocol_q;
  assign seq.oBusy      = busy_q;
  assign seq.oFrameDone = fdone_q;
  assign seq.oOverrun   = ovr_q;
  assign seq.oFrameErr  = ferr_q;

endmodule

// File: tb/tb_isp_frame_sequencer.sv
// Directed, table-driven bench for isp_frame_sequencer on an 8x4 frame.
module tb_isp_frame_sequencer;
  import isp_frame_sequencer_pkg::*;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int HB = 2;
  localparam int SD = 4;
  localparam int FR = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  isp_frame_sequencer_if #(.DATA_W(8), .WIDTH(W), .HEIGHT(H), .FLUSH_ROWS(FR)) sif ();

  isp_frame_sequencer #(
    .DATA_W(8), .WIDTH(W), .HEIGHT(H), .H_BLANK(HB), .START_DELAY(SD), .FLUSH_ROWS(FR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .seq   (sif)
  );

  // One cycle: inputs applied, then outputs expected just after the edge.
  typedef struct packed {
    logic       nf;
    logic       iv;
    logic [7:0] id;
    logic       pd;
    logic       e_nf;
    logic       e_v;
    logic [7:0] e_d;
    logic [2:0] e_row;
    logic [2:0] e_col;
    logic       e_busy;
    logic       e_done;
    logic       e_ovr;
    logic       e_err;
    logic       chk_rc;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic nf, input logic iv, input logic [7:0] id, input logic pd);
    vec_t v = '0;
    v.nf = nf; v.iv = iv; v.id = id; v.pd = pd;
    v.e_busy = 1'b1;
    return v;
  endfunction

  function automatic void b_entry(input logic abort);
    vec_t v = mk(1'b1, 1'b0, 8'h00, 1'b0);
    v.e_nf  = 1'b1;
    v.e_err = abort;
    vq.push_back(v);
  endfunction

  function automatic void b_start(input logic iv_in);
    vec_t v;
    for (int i = 0; i < SD; i++) begin
      v = mk(1'b0, iv_in, 8'hAA, 1'b0);
      v.e_ovr = iv_in;
      vq.push_back(v);
    end
  endfunction

  function automatic void b_pixels(input int n, input int gap, input int seed);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v = mk(1'b0, 1'b1, 8'(i * 13 + seed), 1'b0);
      v.e_v = 1'b1; v.e_d = v.id; v.chk_rc = 1'b1;
      v.e_row = 3'(i / W); v.e_col = 3'(i % W);
      vq.push_back(v);
      if ((i % W) == W - 1 && i != n - 1 && i != H * W - 1)
        for (int g = 0; g < gap; g++) vq.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0));
    end
  endfunction

  function automatic void b_flush(input int nrows, input logic pd_first, input logic ovr_in, input logic nf_mid);
    vec_t v;
    for (int f = 0; f < nrows; f++) begin
      for (int b = 0; b < HB; b++)
        vq.push_back(mk(1'b0, 1'b0, 8'h00, (f == 0 && b == 0) ? pd_first : 1'b0));
      for (int c = 0; c < W; c++) begin
        v = mk(1'b0, 1'b0, 8'h00, 1'b0);
        if (ovr_in && f == 0 && c == 3) begin v.iv = 1'b1; v.id = 8'h55; v.e_ovr = 1'b1; end
        if (nf_mid && f == 1 && c == 2) v.nf = 1'b1;
        v.e_v = 1'b1; v.e_d = 8'h00; v.chk_rc = 1'b1;
        v.e_row = 3'(H + f); v.e_col = 3'(c);
        v.e_done = (f == nrows - 1 && c == W - 1);
        vq.push_back(v);
      end
    end
    v = mk(1'b0, 1'b0, 8'h00, 1'b0);
    v.e_busy = nf_mid;
    v.e_nf   = nf_mid;
    vq.push_back(v);
  endfunction

  task automatic run_table();
    foreach (vq[k]) begin
      sif.newFrame  = vq[k].nf;
      sif.iValid    = vq[k].iv;
      sif.iData     = vq[k].id;
      sif.iPipeDone = vq[k].pd;
      @(posedge clk); #1;
      chk("oNewFrame",  k, 32'(sif.oNewFrame),  32'(vq[k].e_nf));
      chk("oValid",     k, 32'(sif.oValid),     32'(vq[k].e_v));
      chk("oData",      k, 32'(sif.oData),      32'(vq[k].e_d));
      chk("oBusy",      k, 32'(sif.oBusy),      32'(vq[k].e_busy));
      chk("oFrameDone", k, 32'(sif.oFrameDone), 32'(vq[k].e_done));
      chk("oOverrun",   k, 32'(sif.oOverrun),   32'(vq[k].e_ovr));
      chk("oFrameErr",  k, 32'(sif.oFrameErr),  32'(vq[k].e_err));
      if (vq[k].chk_rc) begin
        chk("oRow", k, 32'(sif.oRow), 32'(vq[k].e_row));
        chk("oCol", k, 32'(sif.oCol), 32'(vq[k].e_col));
      end
    end
    vq.delete();
    sif.newFrame = 1'b0; sif.iValid = 1'b0; sif.iData = 8'h00; sif.iPipeDone = 1'b0;
  endtask

  task automatic check_zero(input string name);
    chk(name, 0, 32'({sif.oNewFrame, sif.oValid, sif.oData, sif.oRow, sif.oCol,
                      sif.oBusy, sif.oFrameDone, sif.oOverrun, sif.oFrameErr}), 32'd0);
  endtask

  initial begin
    sif.newFrame = 1'b0; sif.iValid = 1'b0; sif.iData = 8'h00; sif.iPipeDone = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_outputs");
    reset = 1'b0;

    // Nominal frame with 2-cycle row gaps and a full 3-row flush
    b_entry(1'b0); b_start(1'b0); b_pixels(H * W, 2, 3); b_flush(FR, 1'b0, 1'b0, 1'b0);
    run_table();

    // Early drain: pipeline done during the first blanking interval
    b_entry(1'b0); b_start(1'b0); b_pixels(H * W, 0, 50); b_flush(1, 1'b1, 1'b0, 1'b0);
    run_table();

    // Abort after 10 pixels, then a clean restart from (0,0)
    b_entry(1'b0); b_start(1'b0); b_pixels(10, 2, 90);
    b_entry(1'b1); b_start(1'b0); b_pixels(H * W, 2, 120); b_flush(FR, 1'b0, 1'b0, 1'b0);
    run_table();

    // Overruns during START and during a flush row
    b_entry(1'b0); b_start(1'b1); b_pixels(H * W, 1, 7); b_flush(FR, 1'b0, 1'b1, 1'b0);
    run_table();

    // Back-to-back: newFrame in flush goes DONE -> START directly
    b_entry(1'b0); b_start(1'b0); b_pixels(H * W, 0, 11); b_flush(FR, 1'b0, 1'b0, 1'b1);
    b_start(1'b0); b_pixels(H * W, 2, 200); b_flush(FR, 1'b0, 1'b0, 1'b0);
    run_table();

    // Reset in row 2 of ACTIVE, then a clean frame
    b_entry(1'b0); b_start(1'b0); b_pixels(20, 0, 33);
    run_table();
    #2 reset = 1'b1;
    #1;
    check_zero("reset_mid_frame");
    @(posedge clk); #1;
    check_zero("reset_hold");
    chk("no_done_after_reset", 0, 32'(sif.oFrameDone), 32'd0);
    reset = 1'b0;
    b_entry(1'b0); b_start(1'b0); b_pixels(H * W, 2, 77); b_flush(FR, 1'b0, 1'b0, 1'b0);
    run_table();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
